ysyx_25030093_mem_arbiter: RTL

Two-master, one-slave AXI4-Lite arbiter that shares the single memory slave (SRAM model) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the cores' fetch/memory stages and the SRAM. Only one transaction is in flight at a time. Grants are round-robin between IFU and LSU, and a grant is held until that transaction's response handshake completes.

---
 rtl/ysyx_25030093_mem_arbiter_if.sv | 34 +++
 rtl/ysyx_25030093_mem_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// AXI4-Lite bundle (AR/R/AW/W/B) shared by the IFU, LSU and SRAM ports of the arbiter.
// "master" drives requests and "slave" answers them.
interface ysyx_25030093_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Round-robin AXI4-Lite arbiter: IFU (read-only) and LSU share one SRAM slave,
// one transaction in flight, grant held until the response handshake.
module ysyx_25030093_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25030093_mem_arbiter_if.slave  ifu,
  ysyx_25030093_mem_arbiter_if.slave  lsu,
  ysyx_25030093_mem_arbiter_if.master sram
);
  typedef enum logic [1:0] {IDLE, GNT_IFU_RD, GNT_LSU_RD, GNT_LSU_WR} state_t;
  typedef enum logic {M_IFU, M_LSU} master_t;

  state_t  state, state_nxt;
  master_t last_grant;

  logic ifu_req, lsu_req;
  assign ifu_req = ifu.arvalid;
  assign lsu_req = lsu.arvalid | lsu.awvalid;

  // The IFU never writes; its write channels are sunk here.
  logic ifu_unused;
  assign ifu_unused = ^{ifu.awvalid, ifu.awaddr, ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.bready};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= M_IFU;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE)
        last_grant <= (state_nxt == GNT_IFU_RD) ? M_IFU : M_LSU;
    end
  end

  always_comb begin
    state_nxt    = state;
    ifu.arready  = 1'b0;
    ifu.rvalid   = 1'b0;
    ifu.rdata    = {DATA_W{1'b0}};
    ifu.rresp    = 2'b00;
    ifu.awready  = 1'b0;
    ifu.wready   = 1'b0;
    ifu.bvalid   = 1'b0;
    ifu.bresp    = 2'b00;
    lsu.arready  = 1'b0;
    lsu.rvalid   = 1'b0;
    lsu.rdata    = {DATA_W{1'b0}};
    lsu.rresp    = 2'b00;
    lsu.awready  = 1'b0;
    lsu.wready   = 1'b0;
    lsu.bvalid   = 1'b0;
    lsu.bresp    = 2'b00;
    sram.arvalid = 1'b0;
    sram.araddr  = {ADDR_W{1'b0}};
    sram.rready  = 1'b0;
    sram.awvalid = 1'b0;
    sram.awaddr  = {ADDR_W{1'b0}};
    sram.wvalid  = 1'b0;
    sram.wdata   = {DATA_W{1'b0}};
    sram.wstrb   = {(DATA_W/8){1'b0}};
    sram.bready  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the master that did not win last time goes first; an LSU
        // read beats an LSU write presented in the same cycle.
        if (ifu_req && (!lsu_req || last_grant == M_LSU))
          state_nxt = GNT_IFU_RD;
        else if (lsu_req)
          state_nxt = lsu.arvalid ? GNT_LSU_RD : GNT_LSU_WR;
      end
      GNT_IFU_RD: begin
        sram.arvalid = ifu.arvalid;
        sram.araddr  = ifu.araddr;
        ifu.arready  = sram.arready;
        ifu.rvalid   = sram.rvalid;
        ifu.rdata    = sram.rdata;
        ifu.rresp    = sram.rresp;
        sram.rready  = ifu.rready;
        if (sram.rvalid && ifu.rready) state_nxt = IDLE;
      end
      GNT_LSU_RD: begin
        sram.arvalid = lsu.arvalid;
        sram.araddr  = lsu.araddr;
        lsu.arready  = sram.arready;
        lsu.rvalid   = sram.rvalid;
        lsu.rdata    = sram.rdata;
        lsu.rresp    = sram.rresp;
        sram.rready  = lsu.rready;
        if (sram.rvalid && lsu.rready) state_nxt = IDLE;
      end
      GNT_LSU_WR: begin
        sram.awvalid = lsu.awvalid;
        sram.awaddr  = lsu.awaddr;
        lsu.awready  = sram.awready;
        sram.wvalid  = lsu.wvalid;
        sram.wdata   = lsu.wdata;
        sram.wstrb   = lsu.wstrb;
        lsu.wready   = sram.wready;
        lsu.bvalid   = sram.bvalid;
        lsu.bresp    = sram.bresp;
        sram.bready  = lsu.bready;
        if (sram.bvalid && lsu.bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
